// File: rtl/fifo_read_drainer_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_read_drainer_if
// Description : Bundles the FIFO read port (rinc/rdata/rempty) and the
//               downstream valid/ready stream of fifo_read_drainer.
//               master = drainer side, slave = FIFO + downstream side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_read_drainer_if #(
    parameter int WIDTH = 8
);
    logic             rinc;
    logic             rempty;
    logic [WIDTH-1:0] rdata;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output rinc,
        input  rempty,
        input  rdata,
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  rinc,
        output rempty,
        output rdata,
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/fifo_read_drainer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_read_drainer
// Description : Read-side consumer of the async FIFO. Issues pops when the
//               FIFO is non-empty and the skid buffer has credit, tracks
//               reads across the fixed SRAM read latency and presents the
//               returned words on a valid/ready stream in pop order.
//               Optional macro FIFO_READ_DRAINER_STATS_EN adds pop_count and
//               stall_count outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_read_drainer #(
    parameter int WIDTH     = 8,
    parameter int RD_LAT    = 1,
    parameter int BUF_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                flush,
    output logic                busy,
`ifdef FIFO_READ_DRAINER_STATS_EN
    output logic [15:0]         pop_count,
    output logic [15:0]         stall_count,
`endif
    fifo_read_drainer_if.master bus
);

    localparam int c_OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int c_SUM_W = c_OCC_W + 1;
    localparam int c_IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(BUF_DEPTH - 1);
    localparam logic [c_SUM_W-1:0] c_DEPTH    = c_SUM_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [RD_LAT-1:0]  r_lat_sr;
    logic [RD_LAT-1:0]  w_lat_sr_nxt;
    logic [c_OCC_W-1:0] r_inflight;
    logic [c_OCC_W-1:0] r_occ;
    logic [c_IDX_W-1:0] r_head;
    logic [c_IDX_W-1:0] r_tail;
    logic [WIDTH-1:0]   r_buf [BUF_DEPTH];

    logic [c_SUM_W-1:0] w_sum;
    logic               w_credit;
    logic               w_issue;
    logic               w_land;
    logic               w_push;
    logic               w_pop;
    logic               w_valid;

    function automatic logic [c_IDX_W-1:0] f_inc(input logic [c_IDX_W-1:0] idx);
        return (idx == c_IDX_LAST) ? '0 : idx + c_IDX_W'(1);
    endfunction

    // Credit check, issue decision and buffer push/pop qualification.
    always_comb begin
        w_sum        = c_SUM_W'(r_inflight) + c_SUM_W'(r_occ);
        w_credit     = (w_sum < c_DEPTH);
        w_issue      = (r_state == S_RUN) && !bus.rempty && w_credit;
        w_land       = r_lat_sr[RD_LAT-1];
        // Landing words are discarded while flushing or on the flush cycle.
        w_push       = w_land && (r_state != S_FLUSH) && !flush;
        w_valid      = (r_occ != '0);
        w_pop        = w_valid && bus.out_ready && !flush;
        w_lat_sr_nxt = (r_lat_sr << 1) | RD_LAT'(w_issue);
    end

    assign bus.rinc      = w_issue;
    assign bus.out_valid = w_valid;
    assign bus.out_data  = r_buf[r_head];
    assign busy          = (r_inflight != '0) || w_valid || (r_state == S_FLUSH);

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (en) w_state_nxt = S_RUN;
            S_RUN:   if (!en) w_state_nxt = S_IDLE;
            S_FLUSH: if (r_inflight == '0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = S_FLUSH;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read-latency tracking: valid shift register and in-flight counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lat_sr   <= '0;
            r_inflight <= '0;
        end else begin
            r_lat_sr <= w_lat_sr_nxt;
            case ({w_issue, w_land})
                2'b10:   r_inflight <= r_inflight + c_OCC_W'(1);
                2'b01:   r_inflight <= r_inflight - c_OCC_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Skid buffer: capture landing words at the tail, advance head on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if (flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_buf[r_tail] <= bus.rdata;
                r_tail        <= f_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= f_inc(r_head);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + c_OCC_W'(1);
                2'b01:   r_occ <= r_occ - c_OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

`ifdef FIFO_READ_DRAINER_STATS_EN
    logic [15:0] r_pop_cnt;
    logic [15:0] r_stall_cnt;

    // Accepted-word counter (wraps) and credit-stall counter (saturates).
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_pop_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_pop_cnt <= r_pop_cnt + 16'd1;
            end
            if ((r_state == S_RUN) && !bus.rempty && !w_credit && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign pop_count   = r_pop_cnt;
    assign stall_count = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_drainer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_read_drainer
// Description : Self-checking bench. DUT0 uses RD_LAT=1, DUT1 uses RD_LAT=3,
//               both BUF_DEPTH=4, each fed by a small FIFO read-port model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_read_drainer;

    typedef struct {
        logic       en;
        logic       rdy;
        logic       x_rinc;
        logic       x_valid;
        logic [7:0] x_data;
        logic       x_busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] en, flush, ordy, mrst, force_e, fe;
    logic [1:0] rinc_s, rempty_s, oval, busy_s;
    logic [7:0] odata [2];
    logic [7:0] dp [2][3];
    logic [7:0] mem [256];
    int         avail [2];
    int         rptr [2];
    int         exp_idx [2];
    int         acc [2];
    int         checks = 0;
    int         errors = 0;
    vec_t       tbl [20];

    always #5 clk = ~clk;

    fifo_read_drainer_if #(.WIDTH(8)) bus0 ();
    fifo_read_drainer_if #(.WIDTH(8)) bus1 ();

`ifdef FIFO_READ_DRAINER_STATS_EN
    logic [15:0] pc0, sc0, pc1, sc1;
`endif

    fifo_read_drainer #(.WIDTH(8), .RD_LAT(1), .BUF_DEPTH(4)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .en         (en[0]),
        .flush      (flush[0]),
        .busy       (busy_s[0]),
`ifdef FIFO_READ_DRAINER_STATS_EN
        .pop_count  (pc0),
        .stall_count(sc0),
`endif
        .bus        (bus0)
    );

    fifo_read_drainer #(.WIDTH(8), .RD_LAT(3), .BUF_DEPTH(4)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .en         (en[1]),
        .flush      (flush[1]),
        .busy       (busy_s[1]),
`ifdef FIFO_READ_DRAINER_STATS_EN
        .pop_count  (pc1),
        .stall_count(sc1),
`endif
        .bus        (bus1)
    );

    assign rempty_s[0]    = fe[0] | force_e[0];
    assign rempty_s[1]    = fe[1] | force_e[1];
    assign bus0.rempty    = rempty_s[0];
    assign bus1.rempty    = rempty_s[1];
    assign bus0.rdata     = dp[0][0];
    assign bus1.rdata     = dp[1][2];
    assign bus0.out_ready = ordy[0];
    assign bus1.out_ready = ordy[1];
    assign rinc_s[0]      = bus0.rinc;
    assign rinc_s[1]      = bus1.rinc;
    assign oval[0]        = bus0.out_valid;
    assign oval[1]        = bus1.out_valid;
    assign odata[0]       = bus0.out_data;
    assign odata[1]       = bus1.out_data;

    // FIFO read-port model: registered empty flag, rdata delayed by RD_LAT.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mrst[k]) begin
                rptr[k] <= 0;
                fe[k]   <= (avail[k] == 0);
            end else if (rinc_s[k] && !rempty_s[k]) begin
                dp[k][0] <= mem[rptr[k]];
                rptr[k]  <= rptr[k] + 1;
                fe[k]    <= ((avail[k] - rptr[k] - 1) == 0);
            end else begin
                fe[k]    <= ((avail[k] - rptr[k]) == 0);
            end
            dp[k][1] <= dp[k][0];
            dp[k][2] <= dp[k][1];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ordy    = 2'b00;
        en      = 2'b00;
        flush   = 2'b00;
        force_e = 2'b00;
        rst     = 1'b1;
        mrst    = 2'b11;
        tick();
        tick();
        rst        = 1'b0;
        mrst       = 2'b00;
        exp_idx[0] = 0;
        exp_idx[1] = 0;
        acc[0]     = 0;
        acc[1]     = 0;
    endtask

    // Stream monitor: empty guard, word order and occupancy bound.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rempty_s[k] === 1'b1) begin
                chk("rinc_while_empty", 32'(rinc_s[k]), 32'd0);
            end
            if (oval[k] === 1'b1 && ordy[k] === 1'b1) begin
                chk("stream_order", 32'(odata[k]), 32'(mem[exp_idx[k]]));
                exp_idx[k]++;
                acc[k]++;
            end
        end
        if (rst === 1'b0) begin
            checks++;
            if (u_dut0.r_occ > 3'd4 || u_dut1.r_occ > 3'd4) begin
                errors++;
                $display("FAIL occupancy_bound actual=%0d/%0d required<=4", u_dut0.r_occ, u_dut1.r_occ);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int issues;
        for (int i = 0; i < 256; i++) mem[i] = 8'(16 + i);
        avail[0] = 0;
        avail[1] = 0;
        // Streaming vectors for RD_LAT=1: first issue at cycle 1, first word
        // visible at cycle 3, 16 back-to-back words, idle from cycle 19.
        for (int c = 0; c < 20; c++) begin
            tbl[c].en      = 1'b1;
            tbl[c].rdy     = 1'b1;
            tbl[c].x_rinc  = (c >= 1 && c <= 16);
            tbl[c].x_valid = (c >= 3 && c <= 18);
            tbl[c].x_data  = 8'(16 + c - 3);
            tbl[c].x_busy  = (c >= 2 && c <= 18);
        end

        // ---- Reset state and stream ----
        avail[0] = 16;
        do_reset();
        @(negedge clk);
        chk("reset_rinc",  32'(rinc_s[0]), 32'd0);
        chk("reset_valid", 32'(oval[0]),   32'd0);
        chk("reset_data",  32'(odata[0]),  32'd0);
        chk("reset_busy",  32'(busy_s[0]), 32'd0);
        chk("reset_data1", 32'(odata[1]),  32'd0);
        tick();
        for (int c = 0; c < 20; c++) begin
            en[0]   = tbl[c].en;
            ordy[0] = tbl[c].rdy;
            @(negedge clk);
            chk($sformatf("stream_rinc[%0d]", c),  32'(rinc_s[0]), 32'(tbl[c].x_rinc));
            chk($sformatf("stream_valid[%0d]", c), 32'(oval[0]),   32'(tbl[c].x_valid));
            chk($sformatf("stream_busy[%0d]", c),  32'(busy_s[0]), 32'(tbl[c].x_busy));
            if (tbl[c].x_valid) begin
                chk($sformatf("stream_data[%0d]", c), 32'(odata[0]), 32'(tbl[c].x_data));
            end
            tick();
        end
        chk("stream_count", 32'(acc[0]), 32'd16);

        // ---- Backpressure ----
        avail[0] = 10;
        do_reset();
        en[0] = 1'b1;
        issues = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rinc_s[0] && !rempty_s[0]) issues++;
            tick();
        end
        chk("bp_issue_count", 32'(issues), 32'd4);
        @(negedge clk);
        chk("bp_hold_valid", 32'(oval[0]),  32'd1);
        chk("bp_hold_data",  32'(odata[0]), 32'h10);
        ordy[0] = 1'b1;
        for (int i = 0; i < 40 && acc[0] < 10; i++) tick();
        chk("bp_drain_count", 32'(acc[0]), 32'd10);

        // ---- Empty guard: rempty toggling every cycle ----
        avail[0] = 8;
        do_reset();
        en[0]   = 1'b1;
        ordy[0] = 1'b1;
        for (int i = 0; i < 80 && acc[0] < 8; i++) begin
            force_e[0] = i[0];
            tick();
        end
        force_e[0] = 1'b0;
        chk("empty_guard_count", 32'(acc[0]), 32'd8);

        // ---- Flush with 3 buffered and 1 in flight ----
        avail[0] = 10;
        do_reset();
        en[0] = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        chk("flush_pre_occ",      32'(u_dut0.r_occ),      32'd3);
        chk("flush_pre_inflight", 32'(u_dut0.r_inflight), 32'd1);
        chk("flush_pre_rinc",     32'(rinc_s[0]),         32'd0);
        flush[0]   = 1'b1;
        exp_idx[0] = 4;
        tick();
        flush[0] = 1'b0;
        @(negedge clk);
        chk("flush_valid", 32'(oval[0]),   32'd0);
        chk("flush_busy",  32'(busy_s[0]), 32'd1);
        tick();
        @(negedge clk);
        chk("flush_idle_busy",  32'(busy_s[0]),        32'd0);
        chk("flush_idle_state", 32'(u_dut0.r_state),   32'd0);
        chk("flush_idle_rinc",  32'(rinc_s[0]),        32'd0);
        ordy[0] = 1'b1;
        for (int i = 0; i < 40 && acc[0] < 6; i++) tick();
        chk("flush_after_count", 32'(acc[0]), 32'd6);

        // ---- Latency sweep, RD_LAT=3, 64 words with pointer wrap ----
        avail[1] = 64;
        do_reset();
        en[1]   = 1'b1;
        ordy[1] = 1'b1;
        for (int i = 0; i < 150 && acc[1] < 64; i++) tick();
        chk("sweep_count", 32'(acc[1]), 32'd64);
`ifdef FIFO_READ_DRAINER_STATS_EN
        chk("sweep_pop_count", 32'(pc1), 32'd64);
`endif
        @(negedge clk);
        chk("sweep_idle_busy", 32'(busy_s[1]), 32'd0);
        tick();

        // ---- Reset with 2 in flight and 2 buffered ----
        avail[1] = 20;
        do_reset();
        en[1] = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        chk("midrst_inflight", 32'(u_dut1.r_inflight), 32'd2);
        chk("midrst_occ",      32'(u_dut1.r_occ),      32'd2);
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        en[1] = 1'b0;
        @(negedge clk);
        chk("midrst_rinc",  32'(rinc_s[1]), 32'd0);
        chk("midrst_valid", 32'(oval[1]),   32'd0);
        chk("midrst_data",  32'(odata[1]),  32'd0);
        chk("midrst_busy",  32'(busy_s[1]), 32'd0);
        exp_idx[1] = 4;
        acc[1]     = 0;
        tick();
        en[1]   = 1'b1;
        ordy[1] = 1'b1;
        for (int i = 0; i < 60 && acc[1] < 6; i++) tick();
        chk("midrst_after_count", 32'(acc[1]), 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
